// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared definitions for the ID/EX forwarding stage: operand select codes,
// control-bundle bit positions and default widths.
package id_ex_fwd_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CTRL_W_DEF = 8;

    // Bit positions inside the packed EX/MEM/WB control bundle
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;

    // Encodings of the EX-stage 4-way operand mux selects
    typedef enum logic [1:0] {
        SEL_REG   = 2'b00,  // register file value captured in ID
        SEL_EXMEM = 2'b01,  // EX/MEM ALU result
        SEL_MEMWB = 2'b10,  // MEM/WB data
        SEL_IMM   = 2'b11   // immediate (B) or shift amount (A)
    } sel_e;

endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel_gen.sv
// Next-cycle operand mux select for one ALU operand. The instruction now in
// EX will sit in EX/MEM next cycle and the one in MEM will sit in MEM/WB, so
// a hit against EX yields SEL_EXMEM and a hit against MEM yields SEL_MEMWB.
module fwd_sel_gen
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic              src_used,
    input  logic              force_imm,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_dst,
    output sel_e              sel
);

    logic src_live;
    logic ex_hit;
    logic mem_hit;

    // Match the source against the two in-flight writers; youngest wins
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sel      = SEL_REG;
        src_live = src_used && (src_addr != '0);
        ex_hit   = src_live && ex_valid  && ex_we  && (ex_dst  == src_addr);
        mem_hit  = src_live && mem_valid && mem_we && (mem_dst == src_addr);
        if (force_imm) begin
            sel = SEL_IMM;
        end else if (ex_hit) begin
            sel = SEL_EXMEM;
        end else if (mem_hit) begin
            sel = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with registered forwarding selects and load-use
// stall/bubble insertion. Optional macro STALL_CNT_EN adds a free-running
// count of inserted load-use bubbles on output stall_cnt.
module id_ex_fwd_stage
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_b_is_imm,
    input  logic              id_a_is_shamt,
    input  logic [REG_AW-1:0] id_dst_addr,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_valid,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              stall_in,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [31:0]       ex_shamt,
    output logic [REG_AW-1:0] ex_dst_addr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_valid,
    output logic [1:0]        ex_a_sel,
    output logic [1:0]        ex_b_sel,
`ifdef STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              stall_out
);

    // Second-stage copy of the writer info, i.e. the instruction now in MEM
    logic [REG_AW-1:0] mem_dst;
    logic              mem_we;
    logic              mem_valid;

    sel_e              a_sel_nx;
    sel_e              b_sel_nx;
    logic              load_use;
    logic              bubble;
    logic              rs_wb_hit;
    logic              rt_wb_hit;

    fwd_sel_gen #(.REG_AW(REG_AW)) u_sel_a (
        .src_addr (id_rs_addr),
        .src_used (id_rs_used),
        .force_imm(id_a_is_shamt),
        .ex_valid (ex_valid),
        .ex_we    (ex_ctrl[CTRL_REGWRITE]),
        .ex_dst   (ex_dst_addr),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_dst  (mem_dst),
        .sel      (a_sel_nx)
    );

    fwd_sel_gen #(.REG_AW(REG_AW)) u_sel_b (
        .src_addr (id_rt_addr),
        .src_used (id_rt_used),
        .force_imm(id_b_is_imm),
        .ex_valid (ex_valid),
        .ex_we    (ex_ctrl[CTRL_REGWRITE]),
        .ex_dst   (ex_dst_addr),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_dst  (mem_dst),
        .sel      (b_sel_nx)
    );

    // A load in EX cannot forward until it reaches MEM/WB; a taken flush
    // squashes the reader anyway, so it suppresses the stall
    assign load_use = ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_dst_addr != '0) && id_valid
                   && ((id_rs_used && (id_rs_addr == ex_dst_addr))
                    || (id_rt_used && (id_rt_addr == ex_dst_addr)))
                   && !flush;
    assign stall_out = load_use;
    assign bubble    = flush || load_use;

    // The register file is written at the end of the WB cycle, so a same-cycle
    // write to a source register is bypassed into the capture
    assign rs_wb_hit = wb_we && (wb_addr != '0) && (wb_addr == id_rs_addr);
    assign rt_wb_hit = wb_we && (wb_addr != '0) && (wb_addr == id_rt_addr);

    // Pipeline register: hold on stall_in, otherwise shift EX into MEM and
    // capture ID (or a bubble) into EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_shamt    <= '0;
            ex_dst_addr <= '0;
            ex_ctrl     <= '0;
            ex_valid    <= 1'b0;
            ex_a_sel    <= SEL_REG;
            ex_b_sel    <= SEL_REG;
            mem_dst     <= '0;
            mem_we      <= 1'b0;
            mem_valid   <= 1'b0;
        end else if (!stall_in) begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            mem_dst    <= ex_dst_addr;
            mem_we     <= ex_ctrl[CTRL_REGWRITE];
            mem_valid  <= ex_valid;
            ex_rs_data <= rs_wb_hit ? wb_data : id_rs_data;
            ex_rt_data <= rt_wb_hit ? wb_data : id_rt_data;
            ex_imm     <= id_imm;
            ex_shamt   <= {27'd0, id_shamt};
            ex_a_sel   <= a_sel_nx;
            ex_b_sel   <= b_sel_nx;
            if (bubble) begin
                ex_dst_addr <= '0;
                ex_ctrl     <= '0;
                ex_valid    <= 1'b0;
            end else begin
                ex_dst_addr <= id_dst_addr;
                ex_ctrl     <= id_ctrl;
                ex_valid    <= id_valid;
            end
        end
    end

`ifdef STALL_CNT_EN
    // Count load-use bubbles actually inserted; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!stall_in && load_use) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Randomized self-checking bench for id_ex_fwd_stage. The reference model
// tracks in-flight instructions as a two-entry queue (EX, MEM) and derives
// selects by searching it for the youngest writer of each source register.
module tb_id_ex_fwd_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs_addr, id_rt_addr, id_dst_addr, wb_addr;
    logic        id_rs_used, id_rt_used, id_b_is_imm, id_a_is_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm, wb_data;
    logic [4:0]  id_shamt;
    logic [7:0]  id_ctrl;
    logic        id_valid, wb_we, flush, stall_in;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_shamt;
    logic [4:0]  ex_dst_addr;
    logic [7:0]  ex_ctrl;
    logic        ex_valid, stall_out;
    logic [1:0]  ex_a_sel, ex_b_sel;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        bit        valid;
        bit [7:0]  ctrl;
        bit [4:0]  dst;
        bit [31:0] rs_d;
        bit [31:0] rt_d;
        bit [31:0] imm;
        bit [4:0]  shamt;
        bit [1:0]  a_sel;
        bit [1:0]  b_sel;
    } slot_t;

    slot_t       pipe[$];   // pipe[0] = instruction in EX, pipe[1] = in MEM
    int unsigned m_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cnt_before;

    id_ex_fwd_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_shamt     (id_shamt),
        .id_b_is_imm  (id_b_is_imm),
        .id_a_is_shamt(id_a_is_shamt),
        .id_dst_addr  (id_dst_addr),
        .id_ctrl      (id_ctrl),
        .id_valid     (id_valid),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .stall_in     (stall_in),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_shamt     (ex_shamt),
        .ex_dst_addr  (ex_dst_addr),
        .ex_ctrl      (ex_ctrl),
        .ex_valid     (ex_valid),
        .ex_a_sel     (ex_a_sel),
        .ex_b_sel     (ex_b_sel),
`ifdef STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .stall_out    (stall_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        slot_t z;
        z = '{default: 0};
        pipe = {};
        pipe.push_back(z);
        pipe.push_back(z);
        m_cnt = 0;
    endtask

    // Youngest valid in-flight writer of register r decides the source
    function automatic bit [1:0] fwd_src(input bit [4:0] r, input bit used);
        if (!used || r == 5'd0) return 2'b00;
        for (int k = 0; k < 2; k++)
            if (pipe[k].valid && pipe[k].ctrl[0] && pipe[k].dst == r)
                return (k == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    task automatic set_id(input bit v, input bit [4:0] rs, input bit rsu, input bit [4:0] rt,
                          input bit rtu, input bit [4:0] dst, input bit [7:0] ctrl);
        id_valid = v;      id_rs_addr = rs;   id_rs_used = rsu;
        id_rt_addr = rt;   id_rt_used = rtu;  id_dst_addr = dst;  id_ctrl = ctrl;
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_shamt = 5'($urandom);
        id_b_is_imm = 1'b0; id_a_is_shamt = 1'b0;
        flush = 1'b0; stall_in = 1'b0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    endtask

    task automatic rand_inputs();
        set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 7)), 8'($urandom));
        id_b_is_imm   = ($urandom_range(0, 3) == 0);
        id_a_is_shamt = ($urandom_range(0, 7) == 0);
        flush         = ($urandom_range(0, 9) == 0);
        stall_in      = ($urandom_range(0, 9) == 0);
        wb_we         = ($urandom_range(0, 1) == 0);
        wb_addr       = 5'($urandom_range(0, 7));
        wb_data       = $urandom;
    endtask

    // One clock: check stall_out before the edge, advance the model, check EX after
    task automatic cycle();
        bit    exp_stall;
        slot_t s;
        #1;
        exp_stall = pipe[0].valid && pipe[0].ctrl[1] && pipe[0].dst != 5'd0 && id_valid
                 && ((id_rs_used && id_rs_addr == pipe[0].dst) || (id_rt_used && id_rt_addr == pipe[0].dst))
                 && !flush;
        check("stall_out", 32'(stall_out), 32'(exp_stall));
        s = '{default: 0};
        if (!(flush || exp_stall)) begin
            s.valid = id_valid;
            s.ctrl  = id_ctrl;
            s.dst   = id_dst_addr;
        end
        s.rs_d  = (wb_we && wb_addr != 5'd0 && wb_addr == id_rs_addr) ? wb_data : id_rs_data;
        s.rt_d  = (wb_we && wb_addr != 5'd0 && wb_addr == id_rt_addr) ? wb_data : id_rt_data;
        s.imm   = id_imm;
        s.shamt = id_shamt;
        s.a_sel = id_a_is_shamt ? 2'b11 : fwd_src(id_rs_addr, id_rs_used);
        s.b_sel = id_b_is_imm   ? 2'b11 : fwd_src(id_rt_addr, id_rt_used);
        @(posedge clk);
        if (!stall_in) begin
            pipe.push_front(s);
            void'(pipe.pop_back());
            if (exp_stall) m_cnt++;
        end
        #1;
        check("ex_valid", 32'(ex_valid), 32'(pipe[0].valid));
        check("ex_ctrl", 32'(ex_ctrl), 32'(pipe[0].ctrl));
        check("ex_dst", 32'(ex_dst_addr), 32'(pipe[0].dst));
        if (pipe[0].valid) begin
            check("ex_rs_data", ex_rs_data, pipe[0].rs_d);
            check("ex_rt_data", ex_rt_data, pipe[0].rt_d);
            check("ex_imm", ex_imm, pipe[0].imm);
            check("ex_shamt", ex_shamt, {27'd0, pipe[0].shamt});
            check("ex_a_sel", 32'(ex_a_sel), 32'(pipe[0].a_sel));
            check("ex_b_sel", 32'(ex_b_sel), 32'(pipe[0].b_sel));
        end
`ifdef STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    initial begin
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
        rst_n = 1'b0;
        reset_model();
        #12 rst_n = 1'b1;

        // Reset state
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_ctrl", 32'(ex_ctrl), 0);
        check("rst_a_sel", 32'(ex_a_sel), 0);
        check("rst_b_sel", 32'(ex_b_sel), 0);
        check("rst_rs_data", ex_rs_data, 0);

        // EX forward: add $3 then a reader of $3 on both operands
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 8'h01); cycle();
        set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd6, 8'h01); cycle();
        check("exfwd_a", 32'(ex_a_sel), 1);
        check("exfwd_b", 32'(ex_b_sel), 1);

        // Double match: $5 in both EX and MEM, EX wins
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 8'h01); cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 8'h01); cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 8'h01); cycle();
        check("dbl_a", 32'(ex_a_sel), 1);

        // $0 destination never forwards
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h01); cycle();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 8'h01); cycle();
        check("r0_a", 32'(ex_a_sel), 0);
        check("r0_b", 32'(ex_b_sel), 0);

        // Load-use: lw $4 then add reading rt=$4
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 8'h03); cycle();
        set_id(1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 5'd8, 8'h01);
        #1 check("lu_stall", 32'(stall_out), 1);
        cnt_before = m_cnt;
        cycle();
        check("lu_bub_valid", 32'(ex_valid), 0);
        check("lu_bub_ctrl", 32'(ex_ctrl), 0);
        check("lu_after_stall", 32'(stall_out), 0);
        cycle();
        check("lu_valid", 32'(ex_valid), 1);
        check("lu_b_sel", 32'(ex_b_sel), 2);
`ifdef STALL_CNT_EN
        check("lu_cnt", stall_cnt, cnt_before + 1);
`endif

        // WB write-through into the rs capture
        set_id(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd1, 8'h01);
        id_rs_data = 32'h0; wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
        cycle();
        check("wb_thru", ex_rs_data, 32'hDEADBEEF);

        // Flush beats load-use
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 8'h03); cycle();
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd2, 8'h01); flush = 1'b1;
        #1 check("fl_stall", 32'(stall_out), 0);
        cycle();
        check("fl_bub_valid", 32'(ex_valid), 0);
        check("fl_bub_dst", 32'(ex_dst_addr), 0);

        // stall_in beats flush: EX contents held
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 8'h01); cycle();
        set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd9, 8'h02); flush = 1'b1; stall_in = 1'b1;
        cycle();
        check("hold_valid", 32'(ex_valid), 1);
        check("hold_dst", 32'(ex_dst_addr), 6);
        check("hold_ctrl", 32'(ex_ctrl), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset mid-run, no clock edge involved
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 8'h01); cycle();
        check("mr_pre_valid", 32'(ex_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(ex_valid), 0);
        check("mr_ctrl", 32'(ex_ctrl), 0);
        check("mr_dst", 32'(ex_dst_addr), 0);
        check("mr_rs_data", ex_rs_data, 0);
        check("mr_shamt", ex_shamt, 0);
        check("mr_a_sel", 32'(ex_a_sel), 0);
        check("mr_stall", 32'(stall_out), 0);
`ifdef STALL_CNT_EN
        check("mr_cnt", stall_cnt, 0);
`endif
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 8'h01); cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core.
- Captures decoded operands, immediate, register addresses and control from ID.
- Precomputes the registered 2-bit select codes that drive the EX-stage 4-way 32-bit operand muxes for ALU A and ALU B.
- Detects load-use hazards, requests an IF/ID stall and inserts a bubble.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register address width
- CTRL_W, 8, packed EX/MEM/WB control bundle width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs_addr, id_rt_addr  in  REG_AW  source register addresses in ID
- id_rs_used, id_rt_used  in  1  instruction reads rs / rt
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  extended immediate
- id_shamt  in  5  shift amount
- id_b_is_imm  in  1  ALU B takes the immediate
- id_a_is_shamt  in  1  ALU A takes the shift amount
- id_dst_addr  in  REG_AW  destination register (0 = none)
- id_ctrl  in  CTRL_W  control bundle; bit 0 = reg_write, bit 1 = mem_read
- id_valid  in  1  ID holds a real instruction
- wb_we, wb_addr, wb_data  in  1/REG_AW/DATA_W  WB-stage register write
- flush  in  1  squash the ID instruction (taken branch/jump)
- stall_in  in  1  global hold (memory busy)
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
- ex_shamt  out  32  zero-extended shift amount
- ex_dst_addr  out  REG_AW
- ex_ctrl  out  CTRL_W
- ex_valid  out  1
- ex_a_sel, ex_b_sel  out  2  operand mux selects
- stall_out  out  1  hold PC and IF/ID (combinational)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, ex_valid 0. Selects 00.
- Priority per clock edge: stall_in (hold all registers) > flush (bubble) > load-use (bubble) > normal capture.
- A bubble sets ex_valid=0, ex_ctrl=0 and ex_dst_addr=0. The data registers may be loaded with any value.
- Forwarding match, ID vs EX:
  - Condition: rs_addr != 0, rs_used, ex_valid, ex_ctrl[0], ex_dst_addr == rs_addr.
  - Result: next a_sel = 01 (the EX/MEM ALU result next cycle).
- Forwarding match, ID vs MEM:
  - The block keeps an internal second-stage copy of dst_addr, reg_write and valid (mem_*), shifted from ex_* on every non-held edge.
  - On match, next a_sel = 10 (MEM/WB data next cycle).
- EX match has priority over MEM match. Neither match gives 00.
- The same rules apply to rt and b_sel.
- id_b_is_imm=1 forces b_sel=11 regardless of hazards. id_a_is_shamt=1 forces a_sel=11.
- WB write-through: if wb_we and wb_addr != 0 and wb_addr equals rs (or rt) on a capture edge, capture wb_data instead of the register file data.
- Load-use: stall_out=1 when all of the following hold:
  - ex_valid and ex_ctrl[1]
  - ex_dst_addr != 0
  - ex_dst_addr matches a used rs or rt of a valid ID instruction
  - flush=0
- During load-use: the next edge inserts a bubble. The following cycle the same ID instruction is recaptured with sel 10 for the load destination.
- stall_in=1: stall_out is still computed, but no register changes. The mem_* copies also hold.
- ID-to-EX latency: 1 cycle. Throughput: 1 instruction per cycle absent hazards.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], reset to 0.
  - Increments on every edge where a load-use bubble is inserted (stall_in=0, flush=0, stall_out=1).
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - select codes SEL_REG=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10, SEL_IMM=2'b11
  - control bit indices CTRL_REGWRITE=0, CTRL_MEMREAD=1
  - DATA_W and REG_AW defaults
- One natural sub-module: fwd_sel_gen. It is combinational and computes the next select for one operand (address, used, force-imm, EX/MEM match info). It is instantiated twice.

Test Plan:
- Reset mid-run: rst_n low asynchronously while ex_valid=1 -> all outputs 0 immediately, with no clock edge.
- EX forward: add $3 then sub using rs=$3 on back-to-back cycles -> second instruction gets ex_a_sel=01. Same rt -> ex_b_sel=01.
- Double match: $5 written by both EX and MEM-stage instructions -> sel=01 (EX wins). Register $0 as destination -> sel=00.
- Load-use: lw $4, then add using rt=$4 -> stall_out=1 for one cycle, then one bubble (ex_valid=0, ex_ctrl=0), then add captured with ex_b_sel=10. stall_cnt = 1 if enabled.
- WB write-through: wb_we=1, wb_addr=7, wb_data=0xDEADBEEF, id_rs_addr=7, id_rs_data=0x0 -> ex_rs_data=0xDEADBEEF.
- Priority: flush=1 with a load-use condition -> bubble and stall_out=0. stall_in=1 with flush=1 -> registers unchanged.
